nibble_serial_sub: RTL and testbench

Multi-nibble subtractor controller. Computes WIDTH-bit a - b - bin by running the 4-bit borrow-propagate subtractor once per clock, least significant nibble first. Registers the borrow between cycles, feeding each slice's borrow-out into the next slice's borrow-in. Sits directly around the 4-bit subtractor slice: it drives the slice's operands and borrow-in, and it consumes the slice's difference and borrow-out.

---
 rtl/nss_pkg.sv | 18 +
 rtl/nibble_serial_sub_slice.sv | 27 ++
 rtl/nibble_serial_sub.sv | 146 ++++++++++++++
 tb/tb_nibble_serial_sub.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/nss_pkg.sv
// Shared definitions for the nibble-serial subtractor: controller states,
// slice width and a helper that sizes the nibble index register.
package nss_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 4;

    // Bits needed to count nslice nibble steps (at least one bit).
    function automatic int idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_sub_slice.sv
// sub4_slice: purely combinational 4-bit borrow-propagate subtractor.
// d4 = a4 - b4 - bi (mod 16), bo = 1 when a4 < b4 + bi.
module sub4_slice
    import nss_pkg::*;
(
    input  logic [SLICE_W-1:0] a4,
    input  logic [SLICE_W-1:0] b4,
    input  logic               bi,
    output logic [SLICE_W-1:0] d4,
    output logic               bo
);

    // Ripple the borrow bit by bit from the LSB upwards.
    always_comb begin
        logic brw;
        // NOTE: every variable written here gets a value before any branch or
        // loop, so no path can leave one unassigned and infer a latch.
        brw = bi;
        d4  = '0;
        for (int i = 0; i < SLICE_W; i++) begin
            d4[i] = a4[i] ^ b4[i] ^ brw;
            brw   = (~a4[i] & b4[i]) | (~(a4[i] ^ b4[i]) & brw);
        end
        bo = brw;
    end

endmodule

// File: rtl/nibble_serial_sub.sv
// nibble_serial_sub: WIDTH-bit a - b - bin computed one nibble per clock,
// LSB nibble first, through a single time-multiplexed sub4_slice.
// Optional build macro NSS_OVF_EN adds the two's-complement overflow output ovf.
module nibble_serial_sub
    import nss_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef NSS_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = idx_width(NSLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               brw_q, brw_d;
    logic               bout_q, bout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [SLICE_W-1:0] slice_a, slice_b, slice_d;
    logic               slice_bo;

    // Current nibble of each captured operand feeds the shared slice.
    assign slice_a = a_q[SLICE_W*idx_q +: SLICE_W];
    assign slice_b = b_q[SLICE_W*idx_q +: SLICE_W];

    sub4_slice u_slice (
        .a4 (slice_a),
        .b4 (slice_b),
        .bi (brw_q),
        .d4 (slice_d),
        .bo (slice_bo)
    );

`ifdef NSS_OVF_EN
    logic ovf_q, ovf_d;
    assign ovf = ovf_q;
`endif

    // Next-state, datapath and output decode for the IDLE/RUN/DONE controller.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        idx_d   = idx_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef NSS_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    d_d     = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                d_d[SLICE_W*idx_q +: SLICE_W] = slice_d;
                brw_d = slice_bo;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    bout_d  = slice_bo;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = DONE;
`ifdef NSS_OVF_EN
                    // Top nibble is being written now, so its MSB is the result sign.
                    ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) &
                            (slice_d[SLICE_W-1] != a_q[WIDTH-1]);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything, abandoning any op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            idx_q   <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef NSS_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments make every register update from
            // the values present before the edge, independent of statement order.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            idx_q   <= idx_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef NSS_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Directed self-checking bench for nibble_serial_sub (WIDTH=16).
// Build with NSS_OVF_EN defined to exercise the overflow output as well.
module tb_nibble_serial_sub;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         bin;
    logic         busy, done, bout;
    logic [W-1:0] d;
`ifdef NSS_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    // Results captured by run_op for the calling test to compare.
    logic [W-1:0] r_d, r_d0, r_d1, r_d_after;
    logic         r_bout, r_done_after, r_timeout, r_ovf;
    int           r_busy_cycles;

    nibble_serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
`ifdef NSS_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Launch one op with a single start pulse, scramble inputs during RUN and
    // wait (bounded) for done; everything is sampled at negedges.
    task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi_v, input logic bini);
        int i;
        @(negedge clk);
        a = ai; b = bi_v; bin = bini; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 16'hA5A5; b = 16'h5A5A; bin = 1'b1;
        r_d0 = d; r_d1 = '0;
        r_busy_cycles = 0; r_timeout = 1'b1; i = 0;
        while (i < 20 && r_timeout) begin
            if (done) begin
                r_timeout = 1'b0;
            end else begin
                if (busy) r_busy_cycles++;
                if (i == 1) r_d1 = d;
                @(negedge clk);
                i++;
            end
        end
        r_d = d; r_bout = bout;
`ifdef NSS_OVF_EN
        r_ovf = ovf;
`else
        r_ovf = 1'b0;
`endif
        @(negedge clk);
        r_done_after = done; r_d_after = d;
    endtask

    task automatic check_op(input string name, input logic [W-1:0] exp_d, input logic exp_bout);
        total++;
        if (r_timeout) begin bad++; $display("FAIL %s timeout: no done within 20 cycles", name); end
        total++;
        if (r_d !== exp_d) begin bad++; $display("FAIL %s d: got %h want %h", name, r_d, exp_d); end
        total++;
        if (r_bout !== exp_bout) begin bad++; $display("FAIL %s bout: got %b want %b", name, r_bout, exp_bout); end
        total++;
        if (r_busy_cycles !== 4) begin bad++; $display("FAIL %s busy_cycles: got %0d want 4", name, r_busy_cycles); end
        total++;
        if (r_done_after !== 1'b0 || r_d_after !== exp_d) begin
            bad++; $display("FAIL %s hold: done=%b d=%h want done=0 d=%h", name, r_done_after, r_d_after, exp_d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || d !== '0 || bout !== 1'b0) begin
            bad++; $display("FAIL reset_outputs: busy=%b done=%b d=%h bout=%b want all 0", busy, done, d, bout);
        end
`ifdef NSS_OVF_EN
        total++;
        if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        run_op(16'h1234, 16'h0234, 1'b0);
        check_op("basic", 16'h1000, 1'b0);
    endtask

    task automatic test_ripple();
        run_op(16'h0000, 16'h0001, 1'b0);
        check_op("ripple", 16'hFFFF, 1'b1);
        total++;
        if (r_d0 !== 16'h0000) begin bad++; $display("FAIL ripple_d_cleared: got %h want 0000", r_d0); end
        total++;
        if (r_d1 !== 16'h000F) begin bad++; $display("FAIL ripple_d_partial: got %h want 000f", r_d1); end
    endtask

    task automatic test_borrow_in();
        run_op(16'h5000, 16'h5000, 1'b1);
        check_op("bin_equal", 16'hFFFF, 1'b1);
        run_op(16'h5000, 16'h4FFF, 1'b1);
        check_op("bin_zero", 16'h0000, 1'b0);
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        int first_at = -1;
        int second_at = -1;
        logic [W-1:0] d_first = '0;
        logic [W-1:0] d_second = '0;
        logic busy_gap = 1'b1;
        @(negedge clk);
        a = 16'h1234; b = 16'h0234; bin = 1'b0; start = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c == 0) begin a = 16'h0010; b = 16'h0001; end
            if (done) begin
                dones++;
                if (first_at < 0) begin first_at = c; d_first = d; end
                else begin second_at = c; d_second = d; start = 1'b0; end
            end
            if (first_at >= 0 && c == first_at + 1) busy_gap = ~busy;
        end
        start = 1'b0;
        total++;
        if (dones !== 2) begin bad++; $display("FAIL b2b_done_count: got %0d want 2", dones); end
        total++;
        if (first_at !== 4 || second_at !== 9) begin
            bad++; $display("FAIL b2b_done_timing: got %0d,%0d want 4,9", first_at, second_at);
        end
        total++;
        if (d_first !== 16'h1000 || d_second !== 16'h000F) begin
            bad++; $display("FAIL b2b_results: got %h,%h want 1000,000f", d_first, d_second);
        end
        total++;
        if (busy_gap !== 1'b0) begin bad++; $display("FAIL b2b_no_gap: busy low after DONE, want high"); end
    endtask

    task automatic test_reset_mid();
        int late_dones = 0;
        @(negedge clk);
        a = 16'h1234; b = 16'h0234; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || d !== '0 || bout !== 1'b0) begin
            bad++; $display("FAIL reset_mid: busy=%b done=%b d=%h bout=%b want all 0", busy, done, d, bout);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done) late_dones++;
        end
        total++;
        if (late_dones !== 0) begin bad++; $display("FAIL reset_mid_no_done: got %0d pulses want 0", late_dones); end
        run_op(16'hFFFF, 16'h0001, 1'b0);
        check_op("after_reset", 16'hFFFE, 1'b0);
    endtask

`ifdef NSS_OVF_EN
    task automatic test_ovf();
        run_op(16'h7FFF, 16'hFFFF, 1'b0);
        check_op("ovf_set", 16'h8000, 1'b1);
        total++;
        if (r_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set_flag: got %b want 1", r_ovf); end
        run_op(16'h0003, 16'h0001, 1'b0);
        check_op("ovf_clear", 16'h0002, 1'b0);
        total++;
        if (r_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear_flag: got %b want 0", r_ovf); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_ripple();
        test_borrow_in();
        test_back_to_back();
        test_reset_mid();
`ifdef NSS_OVF_EN
        test_ovf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
